pipeline_sequencer: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline. Merges the hazard unit's load-use stall,
//  E-stage taken branches and a multi-cycle multiplier occupying E. Drives every stage's stall/flush

---
 rtl/pipeline_sequencer.sv | 145 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : Priority-resolved stall/flush scheduler for a 5-stage pipeline
//            (load-use stall, E-stage taken branch, multi-cycle multiplier).
//            Optional macro PIPE_PERF_CNT_EN builds saturating stall/flush
//            performance counters; otherwise StallCount/FlushCount read 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer #(
   parameter int MUL_LAT = 4,
   parameter int PCNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              LDRstall,
   input  logic              BranchTakenE,
   input  logic              MulReqE,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic              MulStart,
   output logic              MulResultSel,
   output logic [PCNT_W-1:0] StallCount,
   output logic [PCNT_W-1:0] FlushCount
);

   localparam int                 CNT_W    = $clog2(MUL_LAT);
   localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(MUL_LAT - 2);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mul_start, res_sel;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_m   = 1'b0;
      mul_start = 1'b0;
      res_sel   = 1'b0;

      case (state_q)
         S_BUSY: begin
            // E is frozen on the multiply; branch and load-use requests wait.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            if (cnt_q == CNT_ONE) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            res_sel = (state_q == S_DONE);
            state_d = S_IDLE;
            if (BranchTakenE) begin
               flush_d = 1'b1;
               flush_e = 1'b1;
            end else if (MulReqE && (state_q == S_IDLE)) begin
               mul_start = 1'b1;
               stall_f   = 1'b1;
               stall_d   = 1'b1;
               stall_e   = 1'b1;
               flush_m   = 1'b1;
               if (MUL_LAT == 2) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_INIT;
               end
            end else if (LDRstall) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
         end
      endcase
   end

   // Combinational outputs are forced low for the whole time reset is asserted.
   assign StallF       = reset_n & stall_f;
   assign StallD       = reset_n & stall_d;
   assign StallE       = reset_n & stall_e;
   assign FlushD       = reset_n & flush_d;
   assign FlushE       = reset_n & flush_e;
   assign FlushM       = reset_n & flush_m;
   assign MulStart     = reset_n & mul_start;
   assign MulResultSel = reset_n & res_sel;

`ifdef PIPE_PERF_CNT_EN
   logic [PCNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + PCNT_W'(1);
         end
         if (flush_d && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + PCNT_W'(1);
         end
      end
   end

   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// Testbench for pipeline_sequencer: MUL_LAT=4 and MUL_LAT=2 instances share stimulus;
// constant vector table, hand sequences and randomized run against a cycle-level model.
`default_nettype none

module tb_pipeline_sequencer;

   localparam int PCNT_W = 16;
   localparam int CMAX   = (1 << PCNT_W) - 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic ldr = 1'b0, br = 1'b0, mul = 1'b0;

   logic sf4, sd4, se4, fd4, fe4, fm4, ms4, rs4;
   logic sf2, sd2, se2, fd2, fe2, fm2, ms2, rs2;
   logic [PCNT_W-1:0] sc4, fc4, sc2, fc2;
   logic [7:0] out4, out2;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: stall cycles still owed after this one, and "result due now".
   int m_left [2];
   bit m_done [2];
   int m_sc   [2];
   int m_fc   [2];
   int lat    [2] = '{4, 2};

   always #5 clk = ~clk;

   pipeline_sequencer #(.MUL_LAT(4), .PCNT_W(PCNT_W)) dut4 (
      .clk(clk), .reset_n(reset_n), .LDRstall(ldr), .BranchTakenE(br), .MulReqE(mul),
      .StallF(sf4), .StallD(sd4), .StallE(se4), .FlushD(fd4), .FlushE(fe4), .FlushM(fm4),
      .MulStart(ms4), .MulResultSel(rs4), .StallCount(sc4), .FlushCount(fc4)
   );

   pipeline_sequencer #(.MUL_LAT(2), .PCNT_W(PCNT_W)) dut2 (
      .clk(clk), .reset_n(reset_n), .LDRstall(ldr), .BranchTakenE(br), .MulReqE(mul),
      .StallF(sf2), .StallD(sd2), .StallE(se2), .FlushD(fd2), .FlushE(fe2), .FlushM(fm2),
      .MulStart(ms2), .MulResultSel(rs2), .StallCount(sc2), .FlushCount(fc2)
   );

   // Bit order: StallF StallD StallE FlushD FlushE FlushM MulStart MulResultSel
   assign out4 = {sf4, sd4, se4, fd4, fe4, fm4, ms4, rs4};
   assign out2 = {sf2, sd2, se2, fd2, fe2, fm2, ms2, rs2};

   function automatic logic [7:0] model_exp(int k);
      logic [7:0] e;
      e = 8'h00;
      if (!reset_n) return 8'h00;
      if (m_left[k] > 0) return 8'hE4;
      e[0] = m_done[k];
      if (br)                      e = e | 8'h18;
      else if (!m_done[k] && mul)  e = e | 8'hE6;
      else if (ldr)                e = e | 8'hC8;
      return e;
   endfunction

   function automatic int exp_cnt(int v);
`ifdef PIPE_PERF_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_done[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            logic [7:0] e;
            e = model_exp(k);
            if (e[7] && m_sc[k] < CMAX) m_sc[k]++;
            if (e[4] && m_fc[k] < CMAX) m_fc[k]++;
            if (m_left[k] > 0) begin
               m_left[k]--;
               if (m_left[k] == 0) m_done[k] = 1'b1;
            end else if (e[1]) begin
               m_left[k] = lat[k] - 2;
               m_done[k] = (m_left[k] == 0);
            end else begin
               m_done[k] = 1'b0;
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit l, input bit b, input bit m);
      @(negedge clk);
      ldr = l; br = b; mul = m;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; ldr = 1'b0; br = 1'b0; mul = 1'b1;
      #1;
      check("reset_out4", 32'(out4), 32'h0);
      check("reset_out2", 32'(out2), 32'h0);
      repeat (2) @(negedge clk);
      check("reset_cnt4", 32'(sc4) + 32'(fc4), 32'h0);
      reset_n = 1'b1; mul = 1'b0;
   endtask

   typedef struct {
      bit         l;
      bit         b;
      bit         m;
      logic [7:0] exp;
   } vec_t;

   vec_t vt [21];

   initial begin
      vt[0]  = '{0,0,0,8'h00};
      vt[1]  = '{0,0,1,8'hE6}; vt[2]  = '{0,0,1,8'hE4}; vt[3]  = '{0,0,1,8'hE4};
      vt[4]  = '{0,0,1,8'h01}; vt[5]  = '{0,0,0,8'h00};
      vt[6]  = '{1,0,0,8'hC8}; vt[7]  = '{1,1,0,8'h18}; vt[8]  = '{0,0,0,8'h00};
      vt[9]  = '{0,1,1,8'h18}; vt[10] = '{0,0,0,8'h00};
      vt[11] = '{1,0,1,8'hE6}; vt[12] = '{1,0,0,8'hE4}; vt[13] = '{1,0,0,8'hE4};
      vt[14] = '{1,0,0,8'hC9}; vt[15] = '{0,0,0,8'h00};
      vt[16] = '{0,0,1,8'hE6}; vt[17] = '{0,0,0,8'hE4}; vt[18] = '{0,0,0,8'hE4};
      vt[19] = '{0,1,0,8'h19}; vt[20] = '{0,0,0,8'h00};

      do_reset();
      for (int i = 0; i < 21; i++) begin
         drive(vt[i].l, vt[i].b, vt[i].m);
         check($sformatf("vec%0d", i), 32'(out4), 32'(vt[i].exp));
      end

      // Reset asserted at t1 of a MUL_LAT=4 multiply.
      do_reset();
      drive(0, 0, 1);
      check("abort_t0", 32'(out4), 32'hE6);
      drive(0, 0, 1);
      check("abort_t1", 32'(out4), 32'hE4);
      #2 reset_n = 1'b0;
      #1 check("abort_async", 32'(out4), 32'h0);
      @(negedge clk);
      reset_n = 1'b1; mul = 1'b0;
      #1 check("abort_rel", 32'(out4), 32'h0);
      drive(0, 0, 0);
      check("abort_idle", 32'(out4), 32'h0);
      drive(0, 0, 1);
      check("abort_restart", 32'(out4), 32'hE6);

      // MUL_LAT=2 with MulReqE held high.
      do_reset();
      drive(0, 0, 1); check("lat2_t0", 32'(out2), 32'hE6);
      drive(0, 0, 1); check("lat2_t1", 32'(out2), 32'h01);
      drive(0, 0, 1); check("lat2_t2", 32'(out2), 32'hE6);
      drive(0, 0, 1); check("lat2_t3", 32'(out2), 32'h01);
      drive(0, 0, 0); check("lat2_t4", 32'(out2), 32'h00);

      // One multiply then one branch on the MUL_LAT=4 instance.
      do_reset();
      drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 1);
      drive(0, 1, 0);
      drive(0, 0, 0);
      check("perf_stall", 32'(sc4), 32'(exp_cnt(3)));
      check("perf_flush", 32'(fc4), 32'(exp_cnt(1)));

      // Randomized run against the model, with occasional async resets.
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         reset_n = ($urandom % 150) != 0;
         ldr = ($urandom % 4) == 0;
         br  = ($urandom % 6) == 0;
         mul = ($urandom % 3) == 0;
         #1;
         check("rnd_out4", 32'(out4), 32'(model_exp(0)));
         check("rnd_out2", 32'(out2), 32'(model_exp(1)));
         check("rnd_sc4", 32'(sc4), 32'(exp_cnt(m_sc[0])));
         check("rnd_fc4", 32'(fc4), 32'(exp_cnt(m_fc[0])));
         check("rnd_sc2", 32'(sc2), 32'(exp_cnt(m_sc[1])));
      end
      @(negedge clk);
      reset_n = 1'b1;

`ifdef PIPE_PERF_CNT_EN
      // Stall counter saturation.
      do_reset();
      drive(1, 0, 0);
      repeat (CMAX - 1) @(posedge clk);
      #1 check("sat_pre", 32'(sc4), 32'(CMAX - 1));
      repeat (3) @(posedge clk);
      #1 check("sat_hold", 32'(sc4), 32'(CMAX));
      check("sat_flush", 32'(fc4), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
